// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
// State encoding, port identifiers and the grant encoding helper live here.
package rom_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    // Bit index of the one-hot grant equals the port id.
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: a lone request wins outright, a tie goes
// to the requester that was not served last. Purely combinational.
module rr_arbiter2
    import rom_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = port_onehot(~last);
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one combinational ROM between an instruction-fetch and a data-load port.
// Each access takes grant -> READ -> RESP; a new grant may overlap the RESP cycle.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int ROM_DEPTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [ADDR_BITS-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [DATA_BITS-1:0] if_rdata,
    input  logic                 dm_req,
    input  logic [ADDR_BITS-1:0] dm_addr,
    output logic                 dm_gnt,
    output logic                 dm_rvalid,
    output logic [DATA_BITS-1:0] dm_rdata,
    output logic                 err,
    output logic [ADDR_BITS-1:0] rom_addr,
    output logic                 rom_sel,
    input  logic [DATA_BITS-1:0] rom_dout,
    output state_t               dbg_state
);

    localparam logic [ADDR_BITS-1:0] DEPTH_A = ADDR_BITS'(ROM_DEPTH);

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   port_q;
    logic                   oor_q;
    logic                   last_q;

    logic [1:0]             req_v;
    logic [1:0]             win;
    logic                   accept;
    logic                   win_port;
    logic [ADDR_BITS-1:0]   win_addr;
    logic [DATA_BITS-1:0]   cap_data;

    assign req_v = {dm_req, if_req};

    rr_arbiter2 u_rr (
        .req  (req_v),
        .last (last_q),
        .gnt  (win)
    );

    assign win_port  = win[1] ? PORT_DM : PORT_IF;
    assign win_addr  = win[1] ? dm_addr : if_addr;
    // Out-of-range reads return zero rather than whatever the ROM drives.
    assign cap_data  = oor_q ? '0 : rom_dout;
    assign dbg_state = state_q;

    // Grants are gated by rst so nothing is accepted while reset is held.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        rom_sel  = 1'b0;
        rom_addr = '0;
        case (state_q)
            IDLE, RESP: begin
                if (!rst && (win != 2'b00)) begin
                    accept  = 1'b1;
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                rom_sel  = !oor_q;
                rom_addr = addr_q;
                state_d  = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_gnt    = accept & win[0];
    assign dm_gnt    = accept & win[1];
    assign if_rvalid = (state_q == RESP) && (port_q == PORT_IF);
    assign dm_rvalid = (state_q == RESP) && (port_q == PORT_DM);
    assign err       = (state_q == RESP) && oor_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            port_q   <= PORT_IF;
            oor_q    <= 1'b0;
            last_q   <= PORT_DM;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= win_addr;
                port_q <= win_port;
                oor_q  <= (win_addr >= DEPTH_A);
                last_q <= win_port;
            end
            if (state_q == READ) begin
                if (port_q == PORT_IF) begin
                    if_rdata <= cap_data;
                end else begin
                    dm_rdata <= cap_data;
                end
            end
        end
    end

endmodule
